// File: rtl/port_rd_sram_matcher_pkg.sv
// Shared types, widths and the wrap-aware age compare for the per-port read matcher.
package port_rd_pkg;

  localparam int SRAM_NUM = 32;
  localparam int SRAM_W   = $clog2(SRAM_NUM);
  localparam int TS_W     = 16;
  localparam int AMT_W    = 9;
  localparam int TICK_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // a is older than b when (a-b) mod 2^TS_W is negative; only sound while live stamps span < 2^(TS_W-1)
  function automatic logic ts_older(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    logic [TS_W-1:0] diff;
    diff = a - b;
    return diff[TS_W-1];
  endfunction

endpackage

// File: rtl/port_rd_sram_matcher_cmp.sv
// Combinational wrap-aware timestamp age compare; a_older=1 when a_ts is strictly older than b_ts.
module ts_age_cmp
  import port_rd_pkg::*;
(
  input  logic [TS_W-1:0] a_ts,
  input  logic [TS_W-1:0] b_ts,
  output logic            a_older
);

  assign a_older = ts_older(a_ts, b_ts);

endmodule

// File: rtl/port_rd_sram_matcher.sv
// Per-port read matcher: finds the SRAM holding this port's oldest head packet and issues a held read.
// Optional feature: define RD_ORDER_CHECK_EN to flag reads issued out of arrival order on order_err.
module port_rd_sram_matcher
  import port_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        match_threshold,
  input  logic              rd_ready,
  input  logic [SRAM_W-1:0] matching_sram,
  input  logic [AMT_W-1:0]  packet_amount,
  input  logic [TS_W-1:0]   head_ts,
  input  logic              rd_ack,
  output logic              rd_req,
  output logic [SRAM_W-1:0] rd_sram,
  output logic              rd_done,
  output logic              busy,
  output logic              order_err
);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                found_q, found_d;
  logic [SRAM_W-1:0]   best_sram_q, best_sram_d;
  logic [TS_W-1:0]     best_ts_q, best_ts_d;
  logic                rd_req_q, rd_req_d;
  logic [SRAM_W-1:0]   rd_sram_q, rd_sram_d;
  logic                rd_done_q, rd_done_d;
  logic                head_older;
  logic                candidate;

  ts_age_cmp u_scan_cmp (
    .a_ts    (head_ts),
    .b_ts    (best_ts_q),
    .a_older (head_older)
  );

  // Equal stamps are not older, so the first SRAM scanned keeps the slot on a tie
  assign candidate = (packet_amount != '0) && (!found_q || head_older);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    found_d     = found_q;
    best_sram_d = best_sram_q;
    best_ts_d   = best_ts_q;
    rd_req_d    = rd_req_q;
    rd_sram_d   = rd_sram_q;
    rd_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d   = '0;
        found_d  = 1'b0;
        rd_req_d = 1'b0;
        if (rd_ready) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!rd_ready) begin
          state_d = IDLE;
          found_d = 1'b0;
          tick_d  = '0;
        end else begin
          if (candidate) begin
            best_sram_d = matching_sram;
            best_ts_d   = head_ts;
            found_d     = 1'b1;
          end
          if (tick_q != {TICK_W{1'b1}}) begin
            tick_d = tick_q + 1'b1;
          end
          // The exit decision sees this cycle's candidate and the pre-increment tick
          if (found_d && (tick_q >= {{(TICK_W-5){1'b0}}, match_threshold})) begin
            state_d   = ISSUE;
            rd_req_d  = 1'b1;
            rd_sram_d = best_sram_d;
          end
        end
      end
      ISSUE: begin
        if (rd_ack) begin
          state_d   = DONE;
          rd_req_d  = 1'b0;
          rd_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      found_q     <= 1'b0;
      best_sram_q <= '0;
      best_ts_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_sram_q   <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      found_q     <= found_d;
      best_sram_q <= best_sram_d;
      best_ts_q   <= best_ts_d;
      rd_req_q    <= rd_req_d;
      rd_sram_q   <= rd_sram_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign rd_req  = rd_req_q;
  assign rd_sram = rd_sram_q;
  assign rd_done = rd_done_q;
  assign busy    = (state_q != IDLE);

`ifdef RD_ORDER_CHECK_EN
  logic              handshake;
  logic              best_older_last;
  logic [TS_W-1:0]   last_ts_q, last_ts_d;
  logic              last_valid_q, last_valid_d;
  logic              order_err_q, order_err_d;

  assign handshake = (state_q == ISSUE) && rd_ack;

  ts_age_cmp u_order_cmp (
    .a_ts    (best_ts_q),
    .b_ts    (last_ts_q),
    .a_older (best_older_last)
  );

  // best_ts_q still holds the stamp of the SRAM being read when the handshake lands
  always_comb begin
    last_ts_d    = last_ts_q;
    last_valid_d = last_valid_q;
    order_err_d  = 1'b0;
    if (handshake) begin
      order_err_d  = last_valid_q && best_older_last;
      last_ts_d    = best_ts_q;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ts_q    <= '0;
      last_valid_q <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      last_ts_q    <= last_ts_d;
      last_valid_q <= last_valid_d;
      order_err_q  <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_port_rd_sram_matcher.sv
// Self-checking bench for port_rd_sram_matcher: directed scenarios plus randomized scans against a reference model.
module tb_port_rd_sram_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  match_threshold;
  logic        rd_ready;
  logic [4:0]  matching_sram;
  logic [8:0]  packet_amount;
  logic [15:0] head_ts;
  logic        rd_ack;
  logic        rd_req;
  logic [4:0]  rd_sram;
  logic        rd_done;
  logic        busy;
  logic        order_err;

  int          assertCount = 0;
  int          failCount   = 0;
  int          amtTab[32];
  logic [15:0] tsTab[32];
  logic [15:0] lastTs;
  bit          lastValid;

  port_rd_sram_matcher dut (
    .clk             (clk),
    .rst             (rst),
    .match_threshold (match_threshold),
    .rd_ready        (rd_ready),
    .matching_sram   (matching_sram),
    .packet_amount   (packet_amount),
    .head_ts         (head_ts),
    .rd_ack          (rd_ack),
    .rd_req          (rd_req),
    .rd_sram         (rd_sram),
    .rd_done         (rd_done),
    .busy            (busy),
    .order_err       (order_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present the scan pointer as it sits k cycles after the scan started at p0
  task automatic applyStimulus(input int k, input int p0);
    int idx;
    idx = (p0 + k) % 32;
    matching_sram = idx[4:0];
    packet_amount = amtTab[idx][8:0];
    head_ts       = tsTab[idx];
  endtask

  task automatic clearTab();
    for (int i = 0; i < 32; i++) begin
      amtTab[i] = 0;
      tsTab[i]  = 16'($urandom);
    end
  endtask

  // Model: samples k=0.. visit SRAM (p0+k)%32; issue after sample K=max(thr, first non-empty k);
  // winner is the smallest stamp relative to the first seen one, earliest sample on ties.
  task automatic runScan(input int thr, input int p0, input int ackDelay, input bit doHandshake);
    int          f;
    int          kIssue;
    int          best;
    int          n;
    int          idx;
    bit          issued;
    shortint     rel;
    shortint     bestRel;
    logic [15:0] refTs;
    bit          expErr;
    f = -1;
    for (int k = 0; k < 32; k++) begin
      if (f < 0 && amtTab[(p0 + k) % 32] != 0) f = k;
    end
    if (f < 0) begin
      checkOutput("model_nonempty", 0, 1);
      return;
    end
    kIssue  = (thr > f) ? thr : f;
    refTs   = tsTab[(p0 + f) % 32];
    best    = -1;
    bestRel = 0;
    for (int k = 0; k <= kIssue; k++) begin
      idx = (p0 + k) % 32;
      if (amtTab[idx] != 0) begin
        rel = shortint'(tsTab[idx] - refTs);
        if (best < 0 || rel < bestRel) begin
          best    = idx;
          bestRel = rel;
        end
      end
    end

    rd_ready        = 1'b1;
    match_threshold = thr[4:0];
    applyStimulus(0, p0);
    @(posedge clk); #1;
    checkOutput("busy_enter_scan", busy, 1);

    n = 0;
    issued = 1'b0;
    for (int k = 0; k <= kIssue + 40; k++) begin
      applyStimulus(k, p0);
      @(posedge clk); #1;
      n = k + 1;
      if (rd_req === 1'b1) begin
        issued = 1'b1;
        break;
      end
    end
    checkOutput("issue_seen", issued, 1);
    checkOutput("issue_cycle", n, kIssue + 1);
    checkOutput("rd_sram", rd_sram, best);
    if (!doHandshake) return;

    for (int d = 0; d < ackDelay; d++) begin
      @(posedge clk); #1;
      rd_ready = 1'b0;
      checkOutput("req_held", rd_req, 1);
      checkOutput("sram_stable", rd_sram, best);
      checkOutput("done_early", rd_done, 0);
    end
    rd_ack   = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    rd_ack = 1'b0;
`ifdef RD_ORDER_CHECK_EN
    expErr = lastValid && (shortint'(tsTab[best] - lastTs) < 0);
`else
    expErr = 1'b0;
`endif
    lastTs    = tsTab[best];
    lastValid = 1'b1;
    checkOutput("req_drop", rd_req, 0);
    checkOutput("done_pulse", rd_done, 1);
    checkOutput("order_err", order_err, expErr);
    @(posedge clk); #1;
    checkOutput("done_clear", rd_done, 0);
    checkOutput("order_err_clear", order_err, 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin
    bit          sawReq;
    int          cnt;
    int          idx;
    logic [15:0] base;
    rst             = 1'b1;
    match_threshold = 5'd0;
    rd_ready        = 1'b0;
    matching_sram   = 5'd0;
    packet_amount   = 9'd0;
    head_ts         = 16'd0;
    rd_ack          = 1'b0;
    lastTs          = 16'd0;
    lastValid       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rd_req", rd_req, 0);
    checkOutput("rst_rd_sram", rd_sram, 0);
    checkOutput("rst_rd_done", rd_done, 0);
    checkOutput("rst_order_err", order_err, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;

    $display("[TB] stray rd_ack in IDLE");
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
    checkOutput("ack_idle_busy", busy, 0);
    checkOutput("ack_idle_done", rd_done, 0);

    $display("[TB] strict order across SRAM3/SRAM7");
    clearTab();
    amtTab[3] = 1; tsTab[3] = 16'h0100;
    amtTab[7] = 2; tsTab[7] = 16'h00F0;
    runScan(31, 0, 3, 1'b1);

    $display("[TB] second issue older than the first");
    clearTab();
    amtTab[12] = 1; tsTab[12] = 16'h00E0;
    runScan(31, 0, 2, 1'b1);

    $display("[TB] timestamp wrap");
    clearTab();
    amtTab[4] = 3; tsTab[4] = 16'hFFF0;
    amtTab[9] = 1; tsTab[9] = 16'h0005;
    runScan(31, 0, 0, 1'b1);

    $display("[TB] tie keeps first scanned");
    clearTab();
    amtTab[2] = 1; tsTab[2] = 16'h0042;
    amtTab[5] = 1; tsTab[5] = 16'h0042;
    runScan(31, 0, 1, 1'b1);
    runScan(0, 5, 1, 1'b1);

    $display("[TB] reset while issuing");
    clearTab();
    amtTab[6] = 1; tsTab[6] = 16'h1234;
    runScan(0, 6, 0, 1'b0);
    rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_issue_req", rd_req, 0);
    checkOutput("rst_issue_busy", busy, 0);
    checkOutput("rst_issue_sram", rd_sram, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    lastValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] empty port then abort");
    clearTab();
    rd_ready        = 1'b1;
    match_threshold = 5'd0;
    @(posedge clk); #1;
    checkOutput("empty_busy_enter", busy, 1);
    sawReq = 1'b0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(k, 0);
      @(posedge clk); #1;
      if (rd_req !== 1'b0) sawReq = 1'b1;
    end
    checkOutput("empty_no_req", sawReq, 0);
    checkOutput("empty_still_busy", busy, 1);
    rd_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 0);

    $display("[TB] randomized scans");
    for (int r = 0; r < 12; r++) begin
      clearTab();
      base = 16'($urandom);
      cnt  = $urandom_range(1, 6);
      for (int j = 0; j < cnt; j++) begin
        idx         = $urandom_range(0, 31);
        amtTab[idx] = $urandom_range(1, 511);
        tsTab[idx]  = base + 16'($urandom_range(0, 16'h3FFF));
      end
      runScan($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
